// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline debug sequencer: FSM state encoding,
// host command bytes and the HALT instruction word.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_RST,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_RUN,
        ST_STEP_WAIT,
        ST_STEP_EXEC,
        ST_SEND
    } state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_EXIT = 8'h45;  // 'E'

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_unit_if.sv
// Bundle of UART byte links, pipeline control and instruction-memory write
// port seen by the debug sequencer. The slave modport is the sequencer side.
interface debug_unit_if #(
    parameter int LEN     = 32,
    parameter int IMEM_AW = 8
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_done;
    logic               halt_flag;
    logic [LEN-1:0]     pc_value;
    logic               pipe_enable;
    logic               pipe_reset;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [LEN-1:0]     imem_wdata;

    modport slave (
        input  rx_data, rx_valid, tx_done, halt_flag, pc_value,
        output tx_data, tx_start, pipe_enable, pipe_reset,
               imem_we, imem_addr, imem_wdata
    );

    modport master (
        output rx_data, rx_valid, tx_done, halt_flag, pc_value,
        input  tx_data, tx_start, pipe_enable, pipe_reset,
               imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/tx_serializer.sv
// Sends a multi-byte word MSB first over a tx_start/tx_done byte handshake
// and strobes done_o once the last byte has been acknowledged.
module tx_serializer #(
    parameter int NBYTES = 8,
    parameter int CW     = $clog2(NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [8*NBYTES-1:0]   data_i,
    input  logic [CW-1:0]         nbytes_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_start_o,
    input  logic                  tx_done_i,
    output logic                  done_o
);

    logic [8*NBYTES-1:0] shreg_q;
    logic [CW-1:0]       left_q;
    logic                wait_q;
    logic                tx_start_q;
    logic                done_q;

    // Load, then advance one byte per acknowledged transfer; tx_done with
    // nothing outstanding is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg_q    <= '0;
            left_q     <= '0;
            wait_q     <= 1'b0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            if (load_i) begin
                shreg_q <= data_i;
                left_q  <= nbytes_i;
                if (nbytes_i == '0) begin
                    done_q <= 1'b1;
                end else begin
                    wait_q     <= 1'b1;
                    tx_start_q <= 1'b1;
                end
            end else if (wait_q && tx_done_i) begin
                if (left_q == CW'(1)) begin
                    wait_q <= 1'b0;
                    left_q <= '0;
                    done_q <= 1'b1;
                end else begin
                    shreg_q    <= {shreg_q[8*NBYTES-9:0], 8'h00};
                    left_q     <= left_q - CW'(1);
                    tx_start_q <= 1'b1;
                end
            end
        end
    end

    assign tx_data_o  = shreg_q[8*NBYTES-1 -: 8];
    assign tx_start_o = tx_start_q;
    assign done_o     = done_q;

endmodule

// File: rtl/debug_unit.sv
// Debug sequencer for the MIPS pipeline: loads instruction memory from a
// UART command stream, runs or single-steps the pipeline through its enable,
// and reports PC plus cycle count back over UART after each run or step.
module debug_unit
    import debug_pkg::*;
#(
    parameter int LEN     = 32,
    parameter int IMEM_AW = 8,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         reset,
    debug_unit_if.slave  bus
);

    localparam int WB  = LEN / 8;
    localparam int NB  = WB + CNT_W / 8;
    localparam int BCW = $clog2(WB + 1);
    localparam int SCW = $clog2(NB + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCW-1:0]     bcnt_q;
    logic               imem_we_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [LEN-1:0]     imem_wdata_q;
    logic               pipe_reset_q;
    logic               ser_load_q;
    logic               step_ret_q;
    logic               ser_done;

    // Sequencer FSM; imem_wdata_q doubles as the byte-assembly buffer, since
    // the memory only looks at it while imem_we is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            pipe_reset_q <= 1'b1;
            ser_load_q   <= 1'b0;
            step_ret_q   <= 1'b0;
        end else begin
            imem_we_q    <= 1'b0;
            pipe_reset_q <= 1'b1;
            ser_load_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            CMD_LOAD: begin
                                state_q      <= ST_LOAD_RST;
                                pipe_reset_q <= 1'b0;
                            end
                            CMD_CONT: state_q <= ST_RUN;
                            CMD_STEP: state_q <= ST_STEP_WAIT;
                            default:  state_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD_RST: begin
                    cnt_q       <= '0;
                    imem_addr_q <= '0;
                    bcnt_q      <= '0;
                    state_q     <= ST_LOAD_BYTE;
                end
                ST_LOAD_BYTE: begin
                    if (bus.rx_valid) begin
                        imem_wdata_q <= {imem_wdata_q[LEN-9:0], bus.rx_data};
                        if (bcnt_q == BCW'(WB - 1)) begin
                            bcnt_q    <= '0;
                            imem_we_q <= 1'b1;
                            state_q   <= ST_LOAD_WRITE;
                        end else begin
                            bcnt_q <= bcnt_q + BCW'(1);
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    // HALT ends the program; a full memory ends it without wrapping.
                    if (imem_wdata_q == LEN'(HALT_WORD) || imem_addr_q == '1) begin
                        state_q <= ST_IDLE;
                    end else begin
                        imem_addr_q <= imem_addr_q + IMEM_AW'(1);
                        state_q     <= ST_LOAD_BYTE;
                    end
                end
                ST_RUN: begin
                    if (bus.halt_flag) begin
                        step_ret_q <= 1'b0;
                        ser_load_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STEP_WAIT: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == CMD_NEXT) begin
                            state_q <= ST_STEP_EXEC;
                        end else if (bus.rx_data == CMD_EXIT) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_STEP_EXEC: begin
                    if (!bus.halt_flag) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    step_ret_q <= !bus.halt_flag;
                    ser_load_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (ser_done) begin
                        state_q <= step_ret_q ? ST_STEP_WAIT : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The pipeline is frozen throughout SEND, so PC and count are stable
    // when the serializer loads them on the first SEND cycle.
    tx_serializer #(
        .NBYTES (NB),
        .CW     (SCW)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ser_load_q),
        .data_i     ({bus.pc_value, cnt_q}),
        .nbytes_i   (SCW'(NB)),
        .tx_data_o  (bus.tx_data),
        .tx_start_o (bus.tx_start),
        .tx_done_i  (bus.tx_done),
        .done_o     (ser_done)
    );

    // Enable is gated by halt_flag combinationally so the HALT fetch never advances.
    assign bus.pipe_enable = (state_q == ST_RUN || state_q == ST_STEP_EXEC) && !bus.halt_flag;
    assign bus.pipe_reset  = pipe_reset_q;
    assign bus.imem_we     = imem_we_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.imem_wdata  = imem_wdata_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: reset, program load, continuous run,
// single stepping, transmit back-pressure and a small-memory load.
module tb_debug_unit;

    logic clk;
    logic reset;
    logic spur;
    logic hold;

    debug_unit_if #(.LEN(32), .IMEM_AW(8)) bus1 ();
    debug_unit_if #(.LEN(32), .IMEM_AW(2)) bus2 ();

    debug_unit #(.LEN(32), .IMEM_AW(8), .CNT_W(32)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    debug_unit #(.LEN(32), .IMEM_AW(2), .CNT_W(32)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    assign bus2.rx_data   = bus1.rx_data;
    assign bus2.rx_valid  = bus1.rx_valid;
    assign bus2.tx_done   = bus1.tx_done;
    assign bus2.halt_flag = bus1.halt_flag;
    assign bus2.pc_value  = bus1.pc_value;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int en1   = 0;
    int en2   = 0;
    int prst1 = 0;
    int dly   = 0;
    logic [7:0]  txq [$];
    logic [7:0]  wa1 [$];
    logic [31:0] wd1 [$];
    logic [1:0]  wa2 [$];
    logic [31:0] wd2 [$];

    // Monitors sample on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (reset) begin
            if (bus1.pipe_enable) en1 = en1 + 1;
            if (bus2.pipe_enable) en2 = en2 + 1;
            if (!bus1.pipe_reset) prst1 = prst1 + 1;
            if (bus1.imem_we) begin
                wa1.push_back(bus1.imem_addr);
                wd1.push_back(bus1.imem_wdata);
            end
            if (bus2.imem_we) begin
                wa2.push_back(bus2.imem_addr);
                wd2.push_back(bus2.imem_wdata);
            end
        end
    end

    // UART transmitter model: logs each byte and acknowledges 3 cycles later
    // unless held off; spur injects an unsolicited tx_done.
    always @(negedge clk) begin
        logic fire;
        fire = 1'b0;
        if (bus1.tx_start) begin
            txq.push_back(bus1.tx_data);
            dly = 3;
        end else if (dly > 0 && !hold) begin
            dly = dly - 1;
            if (dly == 0) fire = 1'b1;
        end
        bus1.tx_done = fire | spur;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus1.rx_data  = b;
        bus1.rx_valid = 1'b1;
        tick(1);
        bus1.rx_valid = 1'b0;
        tick(3);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic wait_tx(input int target, input string tag);
        int n = 0;
        while (txq.size() < target && n < 500) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(txq.size()), 64'(target));
    endtask

    task automatic chk_bytes(input int base, input logic [63:0] expw, input string tag);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] got;
            got = (txq.size() > base + i) ? txq[base + i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), 64'(got), 64'(expw[63-8*i -: 8]));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_data"},     64'(bus1.tx_data),     64'h0);
        chk({tag, "_tx_start"},    64'(bus1.tx_start),    64'h0);
        chk({tag, "_pipe_enable"}, 64'(bus1.pipe_enable), 64'h0);
        chk({tag, "_pipe_reset"},  64'(bus1.pipe_reset),  64'h1);
        chk({tag, "_imem_we"},     64'(bus1.imem_we),     64'h0);
        chk({tag, "_imem_addr"},   64'(bus1.imem_addr),   64'h0);
        chk({tag, "_imem_wdata"},  64'(bus1.imem_wdata),  64'h0);
    endtask

    initial begin
        int b1, b2, e0, e2, t0, p0;
        reset          = 1'b0;
        spur           = 1'b0;
        hold           = 1'b0;
        bus1.rx_data   = 8'h00;
        bus1.rx_valid  = 1'b0;
        bus1.halt_flag = 1'b0;
        bus1.pc_value  = 32'h0;

        // Power-on reset values
        tick(3);
        chk_reset_outputs("por");

        // Reset in the middle of loading a word
        reset = 1'b1;
        tick(2);
        send_byte(8'h4C);
        send_byte(8'h20);
        send_byte(8'h08);
        reset = 1'b0;
        tick(2);
        chk_reset_outputs("midload");
        reset = 1'b1;
        tick(2);

        // Two-word program ending in HALT
        b1 = wa1.size();
        p0 = prst1;
        send_byte(8'h4C);
        send_word(32'h2008_0005);
        send_word(32'hFFFF_FFFF);
        tick(4);
        chk("load_we_count", 64'(wa1.size() - b1), 64'd2);
        chk("load_addr0",    64'(wa1[b1]),         64'd0);
        chk("load_data0",    64'(wd1[b1]),         64'h2008_0005);
        chk("load_addr1",    64'(wa1[b1+1]),       64'd1);
        chk("load_data1",    64'(wd1[b1+1]),       64'hFFFF_FFFF);
        chk("pipe_reset_low_cycles", 64'(prst1 - p0), 64'd1);

        // Continuous run, HALT seen on the third enabled cycle
        bus1.pc_value = 32'h0000_0008;
        e0 = en1;
        t0 = txq.size();
        bus1.rx_data  = 8'h43;
        bus1.rx_valid = 1'b1;
        tick(1);
        bus1.rx_valid = 1'b0;
        tick(2);
        bus1.halt_flag = 1'b1;
        wait_tx(t0 + 8, "run_tx_count");
        chk("run_enable_cycles", 64'(en1 - e0), 64'd2);
        chk_bytes(t0, 64'h0000_0008_0000_0002, "run");
        bus1.halt_flag = 1'b0;
        tick(12);

        // Reload (clears the counter), then step twice and exit
        send_byte(8'h4C);
        send_word(32'hFFFF_FFFF);
        tick(4);
        bus1.pc_value = 32'h0000_0010;
        send_byte(8'h53);
        e0 = en1;
        t0 = txq.size();
        send_byte(8'h4E);
        wait_tx(t0 + 8, "step1_tx_count");
        chk("step1_enable_cycles", 64'(en1 - e0), 64'd1);
        chk_bytes(t0, 64'h0000_0010_0000_0001, "step1");
        tick(12);
        e0 = en1;
        t0 = txq.size();
        send_byte(8'h4E);
        wait_tx(t0 + 8, "step2_tx_count");
        chk("step2_enable_cycles", 64'(en1 - e0), 64'd1);
        chk_bytes(t0, 64'h0000_0010_0000_0002, "step2");
        tick(12);
        send_byte(8'h45);
        e0 = en1;
        t0 = txq.size();
        send_byte(8'h4E);
        tick(20);
        chk("after_exit_no_enable", 64'(en1 - e0),        64'd0);
        chk("after_exit_no_tx",     64'(txq.size() - t0), 64'd0);

        // Transmitter back-pressure: tx_done withheld for 50 cycles
        hold           = 1'b1;
        bus1.pc_value  = 32'hA500_0010;
        bus1.halt_flag = 1'b1;
        e0 = en1;
        t0 = txq.size();
        send_byte(8'h43);
        wait_tx(t0 + 1, "hold_first_byte");
        tick(50);
        chk("hold_no_more_start", 64'(txq.size() - t0), 64'd1);
        chk("hold_tx_data",       64'(bus1.tx_data),    64'hA5);
        hold = 1'b0;
        wait_tx(t0 + 8, "hold_tx_count");
        chk_bytes(t0, 64'hA500_0010_0000_0002, "hold");
        chk("hold_enable_cycles", 64'(en1 - e0), 64'd0);
        bus1.halt_flag = 1'b0;
        tick(12);

        // Unsolicited tx_done while idle
        t0 = txq.size();
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        tick(10);
        chk("spurious_done_no_tx", 64'(txq.size() - t0), 64'd0);
        chk("spurious_done_start", 64'(bus1.tx_start),   64'd0);

        // Four-word memory filled by five non-HALT words
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        b1 = wa1.size();
        b2 = wa2.size();
        e2 = en2;
        send_byte(8'h4C);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'h0000_0003);
        send_word(32'h0000_0004);
        send_word(32'h1122_3344);
        tick(6);
        chk("small_we_count",  64'(wa2.size() - b2), 64'd4);
        chk("small_addr0",     64'(wa2[b2]),         64'd0);
        chk("small_addr3",     64'(wa2[b2+3]),       64'd3);
        chk("small_data3",     64'(wd2[b2+3]),       64'h0000_0004);
        chk("small_addr_hold", 64'(bus2.imem_addr),  64'd3);
        chk("small_no_enable", 64'(en2 - e2),        64'd0);
        chk("big_we_count",    64'(wa1.size() - b1), 64'd5);
        chk("big_data4",       64'(wd1[b1+4]),       64'h1122_3344);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
